// File: rtl/tone_synth_pkg.sv
// Shared definitions for the tone synthesiser: FSM states, note divider
// limits for the default scale, and the idle output level.
package tone_synth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // Divider limits for a 50 MHz clock (half-period counts per ROM step)
  localparam logic [31:0] NOTE_C = 32'hBAA;
  localparam logic [31:0] NOTE_D = 32'hA64;
  localparam logic [31:0] NOTE_E = 32'h941;
  localparam logic [31:0] NOTE_G = 32'h7C9;

  localparam int SILENT_DEFAULT = 8;

endpackage

// File: rtl/tone_step_counter.sv
// Shared programmable step divider plus sample ROM address counter.
// One ROM step lasts 2*L clocks, where a limit of 0 behaves as 1.
module tone_step_counter
  import tone_synth_pkg::*;
#(
  parameter int DIV_W  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [DIV_W-1:0]  limit,
  output logic [ADDR_W-1:0] addr,
  output logic              tick,
  output logic              wrap
);

  logic [DIV_W:0]   count;
  logic [DIV_W:0]   term_count;
  logic [DIV_W-1:0] limit_eff;

  // Terminal count detection; tick and wrap are seen by the FSM on the
  // same edge that advances the address
  always_comb begin
    limit_eff  = (limit == '0) ? DIV_W'(1) : limit;
    term_count = {limit_eff, 1'b0} - (DIV_W+1)'(1);
    tick       = run && (count == term_count);
    wrap       = tick && (addr == '1);
  end

  // Divider and address registers; both park at zero while not running
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      count <= '0;
      addr  <= '0;
    end else if (tick) begin
      count <= '0;
      addr  <= addr + ADDR_W'(1);
    end else begin
      count <= count + (DIV_W+1)'(1);
    end
  end

endmodule

// File: rtl/tone_synth.sv
// Note generator: synchronises the button levels, picks the lowest
// requested note, and steps a sample ROM at that note's pitch. Note
// changes and stops only happen at the end of a full ROM period.
module tone_synth
  import tone_synth_pkg::*;
#(
  parameter int NUM_NOTES  = 4,
  parameter int NOTE_IDX_W = 2,
  parameter int DIV_W      = 32,
  parameter logic [NUM_NOTES*DIV_W-1:0] NOTE_LIMITS = {NOTE_G, NOTE_E, NOTE_D, NOTE_C},
  parameter int ADDR_W     = 5,
  parameter int SAMPLE_W   = 4,
  parameter int SILENT_LEVEL = SILENT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_NOTES-1:0]  note_req,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [SAMPLE_W-1:0]   rom_data,
  output logic [SAMPLE_W-1:0]   tono,
  output logic                  active,
  output logic [NOTE_IDX_W-1:0] cur_note,
  output logic                  sample_tick
);

  state_t                state;
  logic [NUM_NOTES-1:0]  sync1;
  logic [NUM_NOTES-1:0]  req_s;
  logic                  req_valid;
  logic [NOTE_IDX_W-1:0] req_idx;
  logic                  change_wanted;
  logic [DIV_W-1:0]      limit;
  logic                  run;
  logic                  tick;
  logic                  wrap;

  // Lowest set request bit has priority. Only the most recent differing
  // request matters, so the pending note is simply the live request
  // whenever it differs from the sounding note.
  always_comb begin
    req_idx = '0;
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      if (req_s[i]) req_idx = NOTE_IDX_W'(i);
    end
    req_valid     = |req_s;
    change_wanted = req_valid && (req_idx != cur_note);
    run           = (state != ST_IDLE);
    limit         = NOTE_LIMITS[int'(cur_note)*DIV_W +: DIV_W];
  end

  tone_step_counter #(
    .DIV_W  (DIV_W),
    .ADDR_W (ADDR_W)
  ) u_step (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .limit (limit),
    .addr  (rom_addr),
    .tick  (tick),
    .wrap  (wrap)
  );

  // Synchroniser, sample output register and note FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= '0;
      req_s       <= '0;
      state       <= ST_IDLE;
      active      <= 1'b0;
      cur_note    <= '0;
      sample_tick <= 1'b0;
      tono        <= SAMPLE_W'(SILENT_LEVEL);
    end else begin
      sync1       <= note_req;
      req_s       <= sync1;
      sample_tick <= tick;
      tono        <= (state == ST_IDLE) ? SAMPLE_W'(SILENT_LEVEL) : rom_data;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            state    <= ST_PLAY;
            active   <= 1'b1;
            cur_note <= req_idx;
          end
        end
        ST_PLAY: begin
          if (!req_valid) begin
            state <= ST_FINISH;
          end else if (wrap && change_wanted) begin
            cur_note <= req_idx;
          end
        end
        ST_FINISH: begin
          if (req_valid) begin
            state <= ST_PLAY;
          end else if (wrap) begin
            state  <= ST_IDLE;
            active <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tone_synth.sv
// Self-checking bench for tone_synth: directed scenarios followed by
// random button activity, every cycle compared against a cycle-level
// behavioural model of the note generator.
module tb_tone_synth;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] note_req;
  logic [2:0] rom_addr;
  logic [3:0] rom_data;
  logic [3:0] tono;
  logic       active;
  logic [1:0] cur_note;
  logic       sample_tick;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int   lim[4] = '{3, 2, 1, 0};
  logic [3:0] m_stage1, m_stage2;
  bit   m_sounding, m_releasing;
  int   m_note, m_cnt, m_addr, m_tono, m_tick;

  tone_synth #(
    .NUM_NOTES    (4),
    .NOTE_IDX_W   (2),
    .DIV_W        (32),
    .NOTE_LIMITS  ({32'd0, 32'd1, 32'd2, 32'd3}),
    .ADDR_W       (3),
    .SAMPLE_W     (4),
    .SILENT_LEVEL (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .note_req    (note_req),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .tono        (tono),
    .active      (active),
    .cur_note    (cur_note),
    .sample_tick (sample_tick)
  );

  // Identity sample ROM
  assign rom_data = {1'b0, rom_addr};

  // 100 MHz-style bench clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: observed=%0d expected=%0d", tag, $time, observed, expected);
    end
  endtask

  // Advance the model by one clock edge given the inputs presented to it
  task automatic modelEdge(input logic [3:0] req, input logic rst);
    int  period, ri;
    bit  rv, terminal, wrapping;
    if (rst) begin
      m_stage1 = 0; m_stage2 = 0;
      m_sounding = 0; m_releasing = 0;
      m_note = 0; m_cnt = 0; m_addr = 0; m_tono = 8; m_tick = 0;
      return;
    end
    rv = (m_stage2 != 0);
    ri = 0;
    for (int i = 3; i >= 0; i--) if (m_stage2[i]) ri = i;
    m_stage2 = m_stage1;
    m_stage1 = req;
    if (!m_sounding) begin
      m_tono = 8; m_tick = 0; m_cnt = 0; m_addr = 0;
      if (rv) begin
        m_sounding = 1; m_releasing = 0; m_note = ri;
      end
    end else begin
      period   = 2 * ((lim[m_note] == 0) ? 1 : lim[m_note]);
      m_tono   = m_addr;
      terminal = (m_cnt == period - 1);
      wrapping = terminal && (m_addr == 7);
      m_cnt    = terminal ? 0 : m_cnt + 1;
      m_addr   = terminal ? (m_addr + 1) % 8 : m_addr;
      m_tick   = terminal;
      if (!m_releasing) begin
        if (!rv) m_releasing = 1;
        else if (wrapping && ri != m_note) m_note = ri;
      end else begin
        if (rv) m_releasing = 0;
        else if (wrapping) m_sounding = 0;
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("rom_addr", int'(rom_addr), m_addr);
    checkOutput("tono", int'(tono), m_tono);
    checkOutput("active", int'(active), int'(m_sounding));
    checkOutput("cur_note", int'(cur_note), m_note);
    checkOutput("sample_tick", int'(sample_tick), m_tick);
  endtask

  // Run n cycles with the given inputs, checking every cycle
  task automatic applyStimulus(input logic [3:0] req, input logic rst, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      compareAll();
      note_req = req;
      reset    = rst;
      modelEdge(req, rst);
    end
  endtask

  // Hold inputs until the model reaches the given address, bounded
  task automatic waitAddr(input logic [3:0] req, input int target, input int budget);
    int spent = 0;
    while (m_addr != target && spent < budget) begin
      applyStimulus(req, 1'b0, 1);
      spent++;
    end
    if (spent >= budget) checkOutput("wait_addr_timeout", int'(rom_addr), target);
  endtask

  // Hold inputs until the model goes idle, bounded
  task automatic waitIdle(input int budget);
    int spent = 0;
    while (m_sounding && spent < budget) begin
      applyStimulus(4'b0000, 1'b0, 1);
      spent++;
    end
    if (spent >= budget) checkOutput("wait_idle_timeout", int'(active), 0);
  endtask

  initial begin
    logic [3:0] r;
    int n;
    reset = 1'b1;
    note_req = 4'b0000;
    modelEdge(note_req, reset);

    // Reset held for two cycles
    applyStimulus(4'b0000, 1'b1, 2);
    applyStimulus(4'b0000, 1'b0, 3);

    // Single note0: 6-cycle steps through a full period and beyond
    applyStimulus(4'b0001, 1'b0, 70);
    waitIdle(200);

    // Two buttons from idle, then switch to note1 mid-period
    applyStimulus(4'b0011, 1'b0, 3);
    waitAddr(4'b0011, 3, 200);
    applyStimulus(4'b0010, 1'b0, 60);
    waitIdle(200);

    // Note3 with a zero limit, released at address 2
    applyStimulus(4'b1000, 1'b0, 3);
    waitAddr(4'b1000, 2, 100);
    applyStimulus(4'b0000, 1'b0, 30);

    // Release and re-press before the wrap
    applyStimulus(4'b0001, 1'b0, 3);
    waitAddr(4'b0001, 1, 100);
    applyStimulus(4'b0000, 1'b0, 10);
    applyStimulus(4'b0001, 1'b0, 30);

    // Reset in the middle of play at address 5
    waitAddr(4'b0001, 5, 200);
    applyStimulus(4'b0001, 1'b1, 1);
    applyStimulus(4'b0001, 1'b0, 20);

    // Random button activity with occasional resets
    for (int s = 0; s < 150; s++) begin
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = 4'b0000;
      n = $urandom_range(1, 40);
      if ($urandom_range(0, 40) == 0) applyStimulus(r, 1'b1, 1);
      applyStimulus(r, 1'b0, n);
    end
    waitIdle(300);
    applyStimulus(4'b0000, 1'b0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
